uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (8N1, 16x oversampled, s_tick driven) among N_REQ byte producers.
//  Round-robin arbitration; captures the winner's byte and issues a one-cycle tx_start.
//  Holds ownership until tx_done_tick, then reports completion to the owning requester.
//  Sits between the producer blocks and the transmitter instance in the UART top level.
// PARAMETERS
//  N_REQ        4       number of requesters (2..8)
//  n            8       data width, equal to the transmitter's n
//  WDOG_CYCLES  200000  clk cycles allowed in WAIT before abort (only with UART_TX_ARB_WDOG_EN)
// PORTS
//  clk           in   1            system clock
//  reset         in   1            synchronous, active-high reset
//  req           in   N_REQ        per-requester send request; level, held until gnt
//  din           in   N_REQ*n      packed bytes; requester i uses din[i*n +: n]
//  gnt           out  N_REQ        one-hot 1-cycle pulse: request accepted, byte captured
//  done          out  N_REQ        one-hot 1-cycle pulse: owner's byte fully sent
//  busy          out  1            high from acceptance until release
//  owner         out  clog2(N_REQ) index of current/last owner
//  tx_start      out  1            to transmitter; 1-cycle pulse
//  tx_din        out  n            to transmitter; registered, stable from tx_start to release
//  tx_done_tick  in   1            from transmitter; end-of-stop-bit pulse
//  timeout       out  1            1-cycle abort pulse; tied 0 without the macro
// BEHAVIOUR
//  - Clock and reset: one clock clk; reset is synchronous and active-high.
//  - Reset values: gnt=0, done=0, busy=0, tx_start=0, tx_din=0, owner=0, timeout=0, state=IDLE.
//    Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
//  - All outputs are registered.
//  - FSM:
//    - IDLE: if |req, pick the first set bit searching last+1, last+2, ... (mod N_REQ).
//      At that edge: tx_din <= din[w], owner <= w, gnt[w] <= 1, tx_start <= 1, busy <= 1; go to START.
//    - START: tx_start, gnt back to 0; go to WAIT.
//    - WAIT: on tx_done_tick: done[owner] <= 1, busy <= 0, last <= owner; go to IDLE.
//  - Latency: req high in IDLE at edge c -> gnt and tx_start high in cycle c+1.
//    tx_done_tick at edge d -> done in cycle d+1. Back-to-back: the next grant is possible at edge d+1.
//  - Requester rules:
//    - Must deassert req in the gnt cycle. req still high after gnt is treated as a new request.
//    - din[i] must be stable while req[i] is high.
//  - tx_done_tick in IDLE or START is ignored. req changes outside IDLE are ignored, with no queueing.
//  - Simultaneous requests: lowest rotated distance from last+1 wins; the others wait (no starvation).
//  - Reset mid-transfer: returns to IDLE and pointer reset; no done pulse.
//    The transmitter shares reset, so the line returns to idle high.
// CONFIGURATION
//  - UART_TX_ARB_WDOG_EN defined:
//    - A cycle counter runs in WAIT. If it reaches WDOG_CYCLES with no tx_done_tick:
//      timeout <= 1, busy <= 0, last <= owner, go to IDLE, no done pulse.
//    - tx_done_tick in the same cycle as expiry: done wins, no timeout.
//  - Not defined: no counter, WAIT lasts indefinitely, timeout constant 0.
// STRUCTURE
//  - uart_pkg: FSM state localparams (IDLE=2'b00, START=2'b01, WAIT=2'b10).
//    Also the default oversample count 16 and frame-length constants shared with the transmitter.
//  - Sub-module rr_pick: combinational round-robin picker.
//    Inputs req and last; outputs any and the winner index.
// TESTING
//  1. Single request: req=4'b0100, din[2]=8'hA5 -> gnt=4'b0100 next cycle, tx_start pulse, tx_din=8'hA5.
//     After the frame, done=4'b0100 and busy falls.
//  2. Fairness: req=4'b1111 held, re-asserted after each gnt -> grant order 0,1,2,3,0.
//     Each byte fully framed, with no overlapping tx_start.
//  3. Back-to-back: req[1] raised during req[0]'s transfer -> gnt[1] exactly one cycle after done[0].
//     No gap frames on the line.
//  4. Reset mid-transfer: assert reset during data bit 3 of 8'h3C.
//     All outputs return to reset values and tx goes high; next req[3] -> granted as first pick.
//  5. Spurious tx_done_tick in IDLE -> no done pulse, no state change.
//  6. With UART_TX_ARB_WDOG_EN and WDOG_CYCLES=50: stub transmitter never ticks.
//     timeout pulses 51 cycles after entry to WAIT; the next request is granted normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: arbiter FSM encoding plus the oversample and frame
// geometry that the transmitter and its arbiter both rely on.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10
  } arb_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

  // s_tick periods needed to put one complete 8N1-style frame on the line
  function automatic int frame_ticks(input int data_bits);
    return (START_BITS + data_bits + STOP_BITS) * OVERSAMPLE;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching from the
// position after the last owner, wrapping modulo N_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic             o_any,
  output logic [IW-1:0]    o_idx
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_any  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    // k runs last+1 .. last+N_REQ, so the previous owner is considered last
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IW'((int'(i_last) + k) % N_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ producers.
// Optional WAIT watchdog enabled by defining UART_TX_ARB_WDOG_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int n           = 8,
  parameter int WDOG_CYCLES = 200000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*n-1:0]       din,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     tx_start,
  output logic [n-1:0]             tx_din,
  input  logic                     tx_done_tick,
  output logic                     timeout
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    r_owner;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;
  logic             r_tx_start;
  logic [n-1:0]     r_tx_din;
  logic             w_any;
  logic [IW-1:0]    w_idx;
  logic             w_expire;
  logic             w_accept;
  logic             w_release;

  rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .i_req (req),
    .i_last(r_last),
    .o_any (w_any),
    .o_idx (w_idx)
  );

`ifdef UART_TX_ARB_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout;

  // A done tick in the expiry cycle takes precedence over the abort
  assign w_expire = (r_state == WAIT) && !tx_done_tick &&
                    (r_wdog == WDOG_W'(WDOG_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (r_state != WAIT) r_wdog <= '0;
      else if (!w_expire)  r_wdog <= r_wdog + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_wdog;

  assign w_unused_wdog = ^32'(WDOG_CYCLES);
  assign w_expire      = 1'b0;
  assign timeout       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = START;
      START:   w_state_nxt = WAIT;
      WAIT:    if (tx_done_tick || w_expire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_accept  = (r_state == IDLE) && w_any;
    w_release = (r_state == WAIT) && (tx_done_tick || w_expire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt      <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_din   <= '0;
      r_owner    <= '0;
      r_last     <= IW'(N_REQ - 1);
    end else begin
      r_gnt      <= '0;
      r_done     <= '0;
      r_tx_start <= 1'b0;
      if (w_accept) begin
        r_gnt      <= N_REQ'(1) << w_idx;
        r_tx_start <= 1'b1;
        r_tx_din   <= din[w_idx*n +: n];
        r_owner    <= w_idx;
        r_busy     <= 1'b1;
      end
      if (w_release) begin
        r_busy <= 1'b0;
        r_last <= r_owner;
        if (tx_done_tick) r_done <= N_REQ'(1) << r_owner;
      end
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign busy     = r_busy;
  assign owner    = r_owner;
  assign tx_start = r_tx_start;
  assign tx_din   = r_tx_din;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; watchdog sequence runs only when
// UART_TX_ARB_WDOG_EN is defined.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int WDOG = 50;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] din_i;
  logic [N-1:0]   gnt, done;
  logic           busy;
  logic [1:0]     owner;
  logic           tx_start;
  logic [W-1:0]   tx_din;
  logic           tx_done_tick;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ      (N),
    .n          (W),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req_i),
    .din         (din_i),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .owner       (owner),
    .tx_start    (tx_start),
    .tx_din      (tx_din),
    .tx_done_tick(tx_done_tick),
    .timeout     (timeout)
  );

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    int             w;
    logic [W-1:0]   exp_byte;
    bit             spur;
    int             wait_cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".tx_start"}, 32'(tx_start), 0);
    chk({tag, ".tx_din"}, 32'(tx_din), 0);
    chk({tag, ".owner"}, 32'(owner), 0);
    chk({tag, ".timeout"}, 32'(timeout), 0);
  endtask

  // Grant from IDLE, walk START and WAIT, finish with a done tick
  task automatic run_xfer(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] d,
                          input int w, input logic [W-1:0] b, input bit spur, input int wc);
    logic [N-1:0] oh;
    oh    = 4'b0001 << w;
    req_i = r;
    din_i = d;
    step();
    chk({tag, ".gnt"}, 32'(gnt), 32'(oh));
    chk({tag, ".tx_start"}, 32'(tx_start), 1);
    chk({tag, ".busy"}, 32'(busy), 1);
    chk({tag, ".owner"}, 32'(owner), 32'(w));
    chk({tag, ".tx_din"}, 32'(tx_din), 32'(b));
    req_i = '0;
    if (spur) tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk({tag, ".gnt_clr"}, 32'(gnt), 0);
    chk({tag, ".start_clr"}, 32'(tx_start), 0);
    step(wc);
    chk({tag, ".busy_wait"}, 32'(busy), 1);
    chk({tag, ".done_wait"}, 32'(done), 0);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'(oh));
    chk({tag, ".busy_rel"}, 32'(busy), 0);
    step();
    chk({tag, ".done_clr"}, 32'(done), 0);
  endtask

  initial begin
    int fair_order[5];
    fair_order = '{0, 1, 2, 3, 0};

    vecs[0] = '{4'b0100, 32'h44A52211, 2, 8'hA5, 1'b0, 5};
    vecs[1] = '{4'b1111, 32'h3C5A6978, 3, 8'h3C, 1'b0, 2};
    vecs[2] = '{4'b1111, 32'hF00F55AA, 0, 8'hAA, 1'b1, 3};
    vecs[3] = '{4'b1111, 32'h01020304, 1, 8'h03, 1'b0, 0};
    vecs[4] = '{4'b1111, 32'h80402010, 2, 8'h40, 1'b0, 4};
    vecs[5] = '{4'b0011, 32'hDEADBEEF, 0, 8'hEF, 1'b0, 1};
    vecs[6] = '{4'b1001, 32'hC0FFEE00, 3, 8'hC0, 1'b1, 2};
    vecs[7] = '{4'b0010, 32'h0000FF00, 1, 8'hFF, 1'b0, 6};
    vecs[8] = '{4'b0001, 32'h12345678, 0, 8'h78, 1'b0, 1};

    reset        = 1'b1;
    req_i        = '0;
    din_i        = '0;
    tx_done_tick = 1'b0;
    step(2);
    chk_reset_vals("reset");
    reset = 1'b0;
    step();

    // Done tick while idle must not produce a done or move the pointer
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("spur_idle.done", 32'(done), 0);
    chk("spur_idle.busy", 32'(busy), 0);
    chk("spur_idle.gnt", 32'(gnt), 0);
    step();

    // All four requesting continuously: rotation 0,1,2,3,0
    req_i = 4'b1111;
    din_i = 32'h33221100;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("fair%0d.gnt", i), 32'(gnt), 32'(4'b0001 << fair_order[i]));
      chk($sformatf("fair%0d.tx_din", i), 32'(tx_din), 32'(8'h11 * fair_order[i]));
      step();
      chk($sformatf("fair%0d.start_clr", i), 32'(tx_start), 0);
      step(3);
      chk($sformatf("fair%0d.no_restart", i), 32'(tx_start), 0);
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      if (i == 4) req_i = '0;
      chk($sformatf("fair%0d.done", i), 32'(done), 32'(4'b0001 << fair_order[i]));
    end
    step();

    for (int i = 0; i < 9; i++)
      run_xfer($sformatf("vec%0d", i), vecs[i].req, vecs[i].din, vecs[i].w,
               vecs[i].exp_byte, vecs[i].spur, vecs[i].wait_cyc);

    // Back-to-back: req[1] raised mid-transfer is granted the cycle after done[0]
    req_i = 4'b0001;
    din_i = 32'h00005A00 | 32'h000000C3;
    step();
    chk("b2b.gnt0", 32'(gnt), 32'h1);
    req_i = '0;
    step(2);
    req_i = 4'b0010;
    step(2);
    chk("b2b.no_gnt_in_wait", 32'(gnt), 0);
    chk("b2b.owner", 32'(owner), 0);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("b2b.done0", 32'(done), 32'h1);
    chk("b2b.gnt_gap", 32'(gnt), 0);
    step();
    chk("b2b.gnt1", 32'(gnt), 32'h2);
    chk("b2b.tx_din1", 32'(tx_din), 32'h5A);
    chk("b2b.done_clr", 32'(done), 0);
    req_i = '0;
    step(3);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("b2b.done1", 32'(done), 32'h2);
    step();

    // Reset while data bit 3 of 8'h3C would be on the line
    req_i = 4'b0100;
    din_i = 32'h003C0000;
    step();
    chk("rst_mid.gnt", 32'(gnt), 32'h4);
    chk("rst_mid.tx_din", 32'(tx_din), 32'h3C);
    req_i = '0;
    step(1 + (START_BITS + 3) * OVERSAMPLE);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_vals("rst_mid");
    step(3);
    chk("rst_mid.no_done", 32'(done), 0);
    run_xfer("rst_after", 4'b1010, 32'hAB00CD00, 1, 8'hCD, 1'b0, 2);

`ifdef UART_TX_ARB_WDOG_EN
    // Transmitter never ticks: abort 51 cycles after entering WAIT
    req_i = 4'b0100;
    din_i = 32'h00770000;
    step();
    chk("wdog.gnt", 32'(gnt), 32'h4);
    req_i = '0;
    step();
    for (int i = 0; i < WDOG; i++) begin
      step();
      chk($sformatf("wdog.quiet%0d", i), 32'(timeout), 0);
    end
    chk("wdog.busy_pre", 32'(busy), 1);
    step();
    chk("wdog.timeout", 32'(timeout), 1);
    chk("wdog.busy", 32'(busy), 0);
    chk("wdog.no_done", 32'(done), 0);
    step();
    chk("wdog.timeout_clr", 32'(timeout), 0);
    run_xfer("wdog_after", 4'b0001, 32'h000000E1, 0, 8'hE1, 1'b0, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
